imem_line_responder: RTL and testbench

//  - Memory-side responder for the cache line-fill interface (mem_read/mem_addr/mem_rdata/mem_ready).
//  - Serves 128-bit line reads to cache_ro/cache_comp after a fixed, programmable latency.
//  - Backing store is an on-chip line array, preloaded through a side write port (bench/boot loader).
//  - Sits between the I-cache and the system memory model in the CPU top.

---
 rtl/imem_line_responder.sv | 173 +++++++++++++++++
 tb/tb_imem_line_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_line_responder.sv
// imem_line_responder: 128-bit line-fill responder with fixed latency and preload port.
// Define IMEM_PREFETCH_EN to add a one-line next-line prefetch buffer.
module imem_line_responder #(
  parameter int LATENCY = 4,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic [27:0]   mem_addr,
  output logic [127:0]  mem_rdata,
  output logic          mem_ready,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [127:0]  ld_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // WAIT is entered one edge after acceptance, so it counts LATENCY-2
  localparam logic [3:0] CNT_WAIT =
    (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [3:0] CNT_PF = 4'(LATENCY - 1);

  logic [127:0]  line_q [2**AW];
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d, req_idx;
  logic          wpf_q, wpf_d;
  logic [127:0]  rd_line;
  logic          pf_hit, pf_pend;
  logic          pf_fill, pf_lost;
  logic          unused_addr_hi;

  assign req_idx        = mem_addr[AW-1:0];
  assign unused_addr_hi = ^mem_addr[27:AW];
  assign busy           = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (ld_we) begin
      line_q[ld_addr] <= ld_data;
    end
  end

`ifdef IMEM_PREFETCH_EN
  logic          pf_valid, pf_busy;
  logic [AW-1:0] pf_idx;
  logic [127:0]  pf_data;
  logic [3:0]    pf_cnt;
  logic          ld_hit, pf_miss;

  assign ld_hit  = ld_we && (ld_addr == pf_idx);
  assign pf_hit  = pf_valid && !ld_hit &&
                   (req_idx == pf_idx);
  assign pf_pend = pf_busy && !ld_hit &&
                   (req_idx == pf_idx);
  assign pf_fill = pf_busy && !ld_hit &&
                   (pf_cnt == 4'd0);
  assign pf_lost = !pf_busy || ld_hit;
  assign pf_miss = (state_q == IDLE) && mem_read &&
                   !pf_hit && !pf_pend;
  assign rd_line = (state_q == IDLE && pf_hit) ?
                   pf_data : line_q[idx_d];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pf_valid <= 1'b0;
      pf_busy  <= 1'b0;
      pf_idx   <= '0;
      pf_data  <= '0;
      pf_cnt   <= 4'd0;
    end else begin
      if (pf_busy && pf_cnt != 4'd0) begin
        pf_cnt <= pf_cnt - 4'd1;
      end
      if (pf_fill) begin
        pf_valid <= 1'b1;
        pf_busy  <= 1'b0;
        pf_data  <= line_q[pf_idx];
      end
      if (ld_hit || pf_miss) begin
        pf_valid <= 1'b0;
        pf_busy  <= 1'b0;
      end
      // every response arms a fetch of the following line
      if (state_d == RESP) begin
        pf_valid <= 1'b0;
        pf_busy  <= 1'b1;
        pf_idx   <= idx_d + AW'(1);
        pf_cnt   <= CNT_PF;
      end
    end
  end
`else
  assign pf_hit  = 1'b0;
  assign pf_pend = 1'b0;
  assign pf_fill = 1'b0;
  assign pf_lost = 1'b1;
  assign rd_line = line_q[idx_d];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wpf_d   = wpf_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read) begin
          idx_d = req_idx;
          cnt_d = CNT_WAIT;
          wpf_d = 1'b0;
          if (pf_hit) begin
            state_d = RESP;
          end else if (pf_pend) begin
            state_d = WAIT;
            wpf_d   = 1'b1;
          end else if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!mem_read) begin
          state_d = IDLE;
        end else if (wpf_q) begin
          if (pf_fill) begin
            state_d = RESP;
          end else if (pf_lost) begin
            wpf_d = 1'b0;
            cnt_d = CNT_WAIT;
          end
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      wpf_q     <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wpf_q     <= wpf_d;
      mem_ready <= (state_d == RESP);
      mem_rdata <= (state_d == RESP) ? rd_line : '0;
    end
  end

endmodule

// File: tb/tb_imem_line_responder.sv
// tb_imem_line_responder: directed table, corner sequences and
// randomized reads checked against a line-array reference model.
module tb_imem_line_responder;

  localparam int LAT = 4;
  localparam int AW  = 8;
`ifdef IMEM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read = 1'b0;
  logic [27:0]   mem_addr = '0;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [127:0]  ld_data = '0;
  logic          busy;

  logic [127:0] model [256];
  int n_chk = 0;
  int n_fail = 0;
  int last_idx = -1;

  typedef struct {
    logic [27:0]  addr;
    logic [127:0] data;
    int           ticks;
  } vec_t;

  always #5 clk = ~clk;

  imem_line_responder #(
    .LATENCY(LAT),
    .AW(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_read(mem_read),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // only the line after the last served one can be prefetched
  function automatic bit auto_exact(input logic [27:0] a);
    int i;
    i = int'(a[7:0]);
    return !(PF && last_idx >= 0 && i == (last_idx + 1) % 256);
  endfunction

  task automatic load(input logic [7:0] i,
                      input logic [127:0] d);
    ld_we = 1'b1;
    ld_addr = i;
    ld_data = d;
    tick();
    ld_we = 1'b0;
    model[i] = d;
  endtask

  task automatic wait_pulse(output int t, output bit quiet);
    t = 0;
    quiet = 1'b1;
    do begin
      tick();
      t++;
      if (!mem_ready && mem_rdata != '0) quiet = 1'b0;
    end while (!mem_ready && t < 40);
  endtask

  task automatic check_idle_after(input string nm);
    tick();
    chk({nm, "_rdy_off"}, 128'(mem_ready), 128'(0));
    chk({nm, "_rdata_off"}, mem_rdata, '0);
    chk({nm, "_busy_off"}, 128'(busy), 128'(0));
  endtask

  task automatic do_read(input string nm, input logic [27:0] a,
                         input int exp_t, input bit exact);
    int t;
    bit quiet;
    logic [127:0] exp_d;
    exp_d = model[a[7:0]];
    mem_read = 1'b1;
    mem_addr = a;
    wait_pulse(t, quiet);
    chk({nm, "_pulse"}, 128'(mem_ready), 128'(1));
    if (exact) chk({nm, "_lat"}, 128'(t), 128'(exp_t));
    else chk({nm, "_lat_max"}, 128'(t <= exp_t), 128'(1));
    chk({nm, "_data"}, mem_rdata, exp_d);
    chk({nm, "_quiet"}, 128'(quiet), 128'(1));
    mem_read = 1'b0;
    if (mem_ready) last_idx = int'(a[7:0]);
    check_idle_after(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int t, t2;
    bit q, seen;
    logic [127:0] d5, old;

    d5 = 128'h0123456789ABCDEF0123456789ABCDEF;

    tick();
    tick();
    chk("rst_ready", 128'(mem_ready), 128'(0));
    chk("rst_rdata", mem_rdata, '0);
    chk("rst_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      load(8'(i), {$urandom, $urandom, $urandom, $urandom});
    end
    load(8'd5, d5);

    tbl[0] = '{28'h0000005, d5, LAT};
    tbl[1] = '{28'h0000105, d5, LAT};
    tbl[2] = '{28'hFFFFF40, model[8'h40], LAT};
    tbl[3] = '{28'h0000000, model[8'h00], LAT};
    tbl[4] = '{28'h00000FF, model[8'hFF], LAT};
    tbl[5] = '{28'h12345A3, model[8'hA3], LAT};
    for (int i = 0; i < 6; i++) begin
      mem_read = 1'b1;
      mem_addr = tbl[i].addr;
      wait_pulse(t, q);
      chk($sformatf("tbl%0d_pulse", i), 128'(mem_ready), 128'(1));
      chk($sformatf("tbl%0d_lat", i), 128'(t), 128'(tbl[i].ticks));
      chk($sformatf("tbl%0d_data", i), mem_rdata, tbl[i].data);
      chk($sformatf("tbl%0d_quiet", i), 128'(q), 128'(1));
      mem_read = 1'b0;
      last_idx = int'(tbl[i].addr[7:0]);
      check_idle_after($sformatf("tbl%0d", i));
    end

    // request seen at edge 0: pulse only in cycle LAT
    mem_read = 1'b1;
    mem_addr = 28'h0000005;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk($sformatf("c%0d_rdy", k), 128'(mem_ready), 128'(k == LAT));
      chk($sformatf("c%0d_rdata", k), mem_rdata, (k == LAT) ? d5 : '0);
      if (k == LAT) mem_read = 1'b0;
    end
    chk("c5_busy", 128'(busy), 128'(0));
    last_idx = 5;

    // read held through RESP, new address the cycle after
    mem_read = 1'b1;
    mem_addr = 28'h0000005;
    wait_pulse(t, q);
    chk("hold_lat", 128'(t), 128'(LAT));
    chk("hold_data", mem_rdata, d5);
    tick();
    chk("hold_nodup", 128'(mem_ready), 128'(0));
    mem_addr = 28'h0000006;
    wait_pulse(t2, q);
    chk("hold2_pulse", 128'(mem_ready), 128'(1));
    if (auto_exact(28'h6)) chk("hold2_gap", 128'(t2 + 1), 128'(LAT + 1));
    else chk("hold2_gap_max", 128'(t2 + 1 <= LAT + 1), 128'(1));
    chk("hold2_data", mem_rdata, model[6]);
    mem_read = 1'b0;
    last_idx = 6;
    check_idle_after("hold2");

    // abort in the second WAIT cycle
    mem_read = 1'b1;
    mem_addr = 28'h0000009;
    tick();
    tick();
    chk("abort_busy_on", 128'(busy), 128'(1));
    mem_read = 1'b0;
    tick();
    chk("abort_busy_off", 128'(busy), 128'(0));
    seen = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      if (mem_ready) seen = 1'b1;
      tick();
    end
    chk("abort_nopulse", 128'(seen), 128'(0));
    do_read("abort_rerd", 28'h9, LAT, auto_exact(28'h9));

    // synchronous reset in the second WAIT cycle
    mem_read = 1'b1;
    mem_addr = 28'h0000105;
    tick();
    tick();
    rst_n = 1'b0;
    mem_read = 1'b0;
    tick();
    chk("rstw_ready", 128'(mem_ready), 128'(0));
    chk("rstw_busy", 128'(busy), 128'(0));
    chk("rstw_rdata", mem_rdata, '0);
    rst_n = 1'b1;
    last_idx = -1;
    seen = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      if (mem_ready) seen = 1'b1;
    end
    chk("rstw_nopulse", 128'(seen), 128'(0));
    do_read("rstw_keep", 28'h5, LAT, 1'b1);

    // preload to the pending line during WAIT is returned
    mem_read = 1'b1;
    mem_addr = 28'h0000105;
    tick();
    ld_we = 1'b1;
    ld_addr = 8'd5;
    ld_data = {4{32'hAAAAAAAA}};
    tick();
    ld_we = 1'b0;
    model[5] = {4{32'hAAAAAAAA}};
    wait_pulse(t2, q);
    chk("ldw_lat", 128'(t2 + 2), 128'(LAT));
    chk("ldw_data", mem_rdata, model[5]);
    mem_read = 1'b0;
    last_idx = 5;
    check_idle_after("ldw");

    // write on the read edge returns the old line
    old = model[10];
    mem_read = 1'b1;
    mem_addr = 28'h000000A;
    seen = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      tick();
      if (mem_ready) seen = 1'b1;
    end
    ld_we = 1'b1;
    ld_addr = 8'd10;
    ld_data = ~old;
    tick();
    ld_we = 1'b0;
    model[10] = ~old;
    chk("ldsame_early", 128'(seen), 128'(0));
    chk("ldsame_pulse", 128'(mem_ready), 128'(1));
    chk("ldsame_old", mem_rdata, old);
    mem_read = 1'b0;
    last_idx = 10;
    check_idle_after("ldsame");
    do_read("ldsame_new", 28'hA, LAT, 1'b1);

    // next-line prefetch
    do_read("pf7", 28'h7, LAT, auto_exact(28'h7));
    for (int k = 0; k < LAT + 2; k++) tick();
    do_read("pf8", 28'h8, PF ? 1 : LAT, 1'b1);
    do_read("pf20", 28'h14, LAT, auto_exact(28'h14));

    for (int n = 0; n < 50; n++) begin
      logic [27:0] a;
      int gap, k;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      if ($urandom_range(0, 2) == 0) begin
        load(8'($urandom), {$urandom, $urandom, $urandom, $urandom});
      end
      a = 28'($urandom);
      if ($urandom_range(0, 4) == 0 && auto_exact(a)) begin
        k = $urandom_range(1, LAT - 1);
        mem_read = 1'b1;
        mem_addr = a;
        seen = 1'b0;
        for (int j = 0; j < k; j++) begin
          tick();
          if (mem_ready) seen = 1'b1;
        end
        mem_read = 1'b0;
        tick();
        if (mem_ready) seen = 1'b1;
        chk("rnd_abort_nopulse", 128'(seen), 128'(0));
        chk("rnd_abort_busy", 128'(busy), 128'(0));
      end else begin
        do_read("rnd", a, LAT, auto_exact(a));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
